// File: rtl/multi_phase_carrier_gen.sv
// Multi-channel triangle / sawtooth carrier generator with per-channel phase offsets.
// Configuration is double-buffered and swapped in at channel 0 period boundaries.
module multi_phase_carrier_gen #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_CH    = 4
) (
  input  logic                        MClk,
  input  logic                        Rst,
  input  logic                        En,
  input  logic [1:0]                  Mode,
  input  logic [BIT_WIDTH-1:0]        UpperLimit,
  input  logic [BIT_WIDTH-1:0]        LowerLimit,
  input  logic [BIT_WIDTH-1:0]        StepSize,
  input  logic [NUM_CH*BIT_WIDTH-1:0] PhaseOffset,
  input  logic                        CfgLoad,
  output logic [NUM_CH*BIT_WIDTH-1:0] Wave,
  output logic [NUM_CH-1:0]           Dir,
  output logic [NUM_CH-1:0]           PeakStb,
  output logic [NUM_CH-1:0]           ValleyStb,
  output logic                        CfgPending,
  output logic                        CfgErr,
  output logic                        Running
);
  localparam int W = BIT_WIDTH;
  localparam logic [1:0] MODE_SAW_UP = 2'd1;
  localparam logic [1:0] MODE_SAW_DN = 2'd2;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [1:0]          mode;
    logic [W-1:0]        upper, lower, step;
    logic [NUM_CH*W-1:0] offset;
  } cfg_t;

  typedef struct packed {
    logic         peak;
    logic         valley;
    logic         dir;
    logic [W-1:0] val;
  } ch_t;

  // Start state as {dir, value}; all arithmetic carries one extra bit.
  function automatic logic [W:0] start_state(logic [1:0] mode, logic [W-1:0] upper,
                                             logic [W-1:0] lower, logic [W-1:0] off);
    logic [W:0] u, l, r, oe, sum;
    logic       d;
    u = {1'b0, upper};
    l = {1'b0, lower};
    r = u - l;
    oe = {1'b0, off};
    if (mode == MODE_SAW_UP) begin
      if (oe > r) oe = r;
      sum = l + oe;
      d   = 1'b1;
    end else if (mode == MODE_SAW_DN) begin
      if (oe > r) oe = r;
      sum = u - oe;
      d   = 1'b0;
    end else begin
      if (oe > (r << 1)) oe = r << 1;
      sum = l + oe;
      d   = 1'b1;
      if (sum > u) begin
        sum = u - (oe - r);
        d   = 1'b0;
      end
    end
    return {d, W'(sum)};
  endfunction

  function automatic ch_t step_state(logic [1:0] mode, logic [W-1:0] upper, logic [W-1:0] lower,
                                     logic [W-1:0] step, logic [W-1:0] w_in, logic dir_in);
    logic [W:0] u, l, s, w, nxt;
    ch_t        n;
    u = {1'b0, upper};
    l = {1'b0, lower};
    s = {1'b0, step};
    w = {1'b0, w_in};
    n = '0;
    n.dir = dir_in;
    if (mode == MODE_SAW_UP) begin
      if (w + s > u) begin nxt = l; n.peak = 1'b1; end
      else nxt = w + s;
    end else if (mode == MODE_SAW_DN) begin
      if (w - l < s) begin nxt = u; n.valley = 1'b1; end
      else nxt = w - s;
    end else if (dir_in) begin
      if (w + s > u) begin
        nxt = u - (s - (u - w)); n.dir = 1'b0; n.peak = 1'b1;
      end else nxt = w + s;
    end else begin
      if (w - l < s) begin
        nxt = l + (s - (w - l)); n.dir = 1'b1; n.valley = 1'b1;
      end else nxt = w - s;
    end
    n.val = W'(nxt);
    return n;
  endfunction

  state_e              state_q;
  cfg_t                pend_q, act_q, cfg_in;
  logic                pend_valid_q, act_valid_q, err_q;
  logic [NUM_CH*W-1:0] wave_q;
  logic [NUM_CH-1:0]   dir_q, peak_q, valley_q;

  logic [W:0]          in_range;
  logic                cfg_ok, boundary, apply;
  logic [1:0]          src_mode;
  logic [W-1:0]        src_upper, src_lower;
  logic [NUM_CH*W-1:0] src_offset;
  logic [W:0]          start_s [NUM_CH];
  ch_t                 step_s  [NUM_CH];

  assign cfg_in   = {Mode, UpperLimit, LowerLimit, StepSize, PhaseOffset};
  assign in_range = {1'b0, UpperLimit} - {1'b0, LowerLimit};
  assign cfg_ok   = (UpperLimit > LowerLimit) && (StepSize != '0) && ({1'b0, StepSize} <= in_range);

  // Channel 0 wrap decides the period boundary; a pending set is swapped in there.
  assign boundary = (act_q.mode == MODE_SAW_UP) ? step_s[0].peak : step_s[0].valley;
  assign apply    = pend_valid_q && ((state_q == IDLE) || (En && boundary));

  assign src_mode   = apply ? pend_q.mode   : act_q.mode;
  assign src_upper  = apply ? pend_q.upper  : act_q.upper;
  assign src_lower  = apply ? pend_q.lower  : act_q.lower;
  assign src_offset = apply ? pend_q.offset : act_q.offset;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      start_s[i] = start_state(src_mode, src_upper, src_lower, src_offset[i*W +: W]);
      step_s[i]  = step_state(act_q.mode, act_q.upper, act_q.lower, act_q.step,
                              wave_q[i*W +: W], dir_q[i]);
    end
  end

  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      act_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      wave_q       <= '0;
      dir_q        <= '1;
      peak_q       <= '0;
      valley_q     <= '0;
    end else begin
      if (CfgLoad) begin
        if (cfg_ok) begin
          pend_q       <= cfg_in;
          pend_valid_q <= 1'b1;
          err_q        <= 1'b0;
        end else begin
          pend_valid_q <= 1'b0;
          err_q        <= 1'b1;
        end
      end else if (apply) begin
        pend_valid_q <= 1'b0;
      end
      if (apply) begin
        act_q       <= pend_q;
        act_valid_q <= 1'b1;
      end

      // NOTE: strobes default low here so they are single-cycle pulses; the step branch overrides.
      peak_q   <= '0;
      valley_q <= '0;
      if (state_q == RUN && En && !apply) begin
        for (int i = 0; i < NUM_CH; i++) begin
          wave_q[i*W +: W] <= step_s[i].val;
          dir_q[i]         <= step_s[i].dir;
          peak_q[i]        <= step_s[i].peak;
          valley_q[i]      <= step_s[i].valley;
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          wave_q[i*W +: W] <= start_s[i][W-1:0];
          dir_q[i]         <= start_s[i][W];
        end
      end

      case (state_q)
        IDLE:    if (En && act_valid_q) state_q <= RUN;
        RUN:     if (!En) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Wave       = wave_q;
  assign Dir        = dir_q;
  assign PeakStb    = peak_q;
  assign ValleyStb  = valley_q;
  assign CfgPending = pend_valid_q;
  assign CfgErr     = err_q;
  assign Running    = (state_q == RUN);
endmodule
